// File: rtl/req_fifo_mc.sv
// req_fifo_mc: per-channel requestor queues drained over a register-mapped bus port.
// Optional interrupt output and per-channel IRQ_MASK register: define REQ_FIFO_MC_IRQ_EN.
module req_fifo_mc #(
  parameter int DATA_W = 5,
  parameter int DEPTH  = 16,
  parameter int NCH    = 2,
  parameter int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           push,
  input  logic [NCH*DATA_W-1:0]    push_data,
  output logic [NCH-1:0]           overflow,
`ifdef REQ_FIFO_MC_IRQ_EN
  output logic                     irq,
`endif
  input  logic                     bus_ren,
  input  logic                     bus_wen,
  input  logic [CH_W+2:0]          bus_addr,
  input  logic [31:0]              bus_wdata,
  output logic [31:0]              bus_rdata,
  output logic                     bus_error
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int AW    = CH_W + 3;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CH_W:0]    NCH_C   = (CH_W + 1)'(NCH);

  localparam logic [2:0] REG_COUNT    = 3'd0;
  localparam logic [2:0] REG_STATUS   = 3'd1;
  localparam logic [2:0] REG_POP      = 3'd2;
  localparam logic [2:0] REG_PEEK     = 3'd3;
  localparam logic [2:0] REG_IRQ_MASK = 3'd4;

  logic [CH_W-1:0] acc_ch;
  logic [2:0]      acc_reg;
  logic            reg_rsv;
  logic            wr_ro;
  logic            acc_err;
  logic            rd_ok;
  logic            wr_ok;

  logic [31:0] rd_val [NCH];
  logic [31:0] rd_mux;
  logic [31:0] bus_rdata_d, bus_rdata_q;
  logic        bus_error_d, bus_error_q;
  logic [NCH-1:0] irq_src;
  logic        unused_wdata;

  assign unused_wdata = ^bus_wdata[31:2];

  always_comb begin
    acc_ch  = bus_addr[AW-1:3];
    acc_reg = bus_addr[2:0];
`ifdef REQ_FIFO_MC_IRQ_EN
    reg_rsv = (acc_reg > REG_IRQ_MASK);
`else
    reg_rsv = (acc_reg >= REG_IRQ_MASK);
`endif
    wr_ro   = bus_wen & ((acc_reg == REG_COUNT) | (acc_reg == REG_POP) | (acc_reg == REG_PEEK));
    // Any rejected access is side-effect free: rd_ok/wr_ok gate every state change.
    acc_err = (bus_ren & bus_wen)
            | ((bus_ren | bus_wen) & (({1'b0, acc_ch} >= NCH_C) | reg_rsv | wr_ro));
    rd_ok   = bus_ren & ~acc_err;
    wr_ok   = bus_wen & ~acc_err;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [DATA_W-1:0] mem [DEPTH];
      logic [DATA_W-1:0] head;
      logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
      logic [CNT_W-1:0]  count_q, count_d;
      logic              ovf_q, ovf_d, udr_q, udr_d;
      logic [2:0]        mask_q, mask_d;
      logic              sel, empty, full, pop_req, pop_ok, push_ok, stat_wr;

      always_comb begin
        sel     = (acc_ch == CH_W'(gi));
        empty   = (count_q == '0);
        full    = (count_q == DEPTH_C);
        pop_req = rd_ok & sel & (acc_reg == REG_POP);
        pop_ok  = pop_req & ~empty;
        // A same-cycle pop frees the slot being written, so a full queue still accepts.
        push_ok = push[gi] & (~full | pop_req);
        stat_wr = wr_ok & sel & (acc_reg == REG_STATUS);
        wptr_d  = wptr_q + PTR_W'(push_ok);
        rptr_d  = rptr_q + PTR_W'(pop_ok);
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        ovf_d   = (ovf_q & ~(stat_wr & bus_wdata[0])) | (push[gi] & full & ~pop_req);
        udr_d   = (udr_q & ~(stat_wr & bus_wdata[1])) | (pop_req & empty);
`ifdef REQ_FIFO_MC_IRQ_EN
        mask_d  = (wr_ok & sel & (acc_reg == REG_IRQ_MASK)) ? bus_wdata[2:0] : mask_q;
`else
        mask_d  = 3'b000;
`endif
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          wptr_q  <= '0;
          rptr_q  <= '0;
          count_q <= '0;
          ovf_q   <= 1'b0;
          udr_q   <= 1'b0;
          mask_q  <= 3'b000;
        end else begin
          wptr_q  <= wptr_d;
          rptr_q  <= rptr_d;
          count_q <= count_d;
          ovf_q   <= ovf_d;
          udr_q   <= udr_d;
          mask_q  <= mask_d;
        end
      end

      always_ff @(posedge clk) begin
        if (push_ok && !rst) begin
          mem[wptr_q] <= push_data[gi*DATA_W +: DATA_W];
        end
      end

      assign head = empty ? '0 : mem[rptr_q];

      always_comb begin
        rd_val[gi] = '0;
        case (acc_reg)
          REG_COUNT:    rd_val[gi] = 32'(count_q);
          REG_STATUS:   rd_val[gi] = {28'd0, full, empty, udr_q, ovf_q};
          REG_POP,
          REG_PEEK:     rd_val[gi] = 32'(head);
          REG_IRQ_MASK: rd_val[gi] = 32'(mask_q);
          default:      rd_val[gi] = '0;
        endcase
      end

      assign overflow[gi] = ovf_q;
      assign irq_src[gi]  = |(mask_q & {udr_q, ovf_q, ~empty});
    end
  endgenerate

  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NCH; c++) begin
      if (acc_ch == CH_W'(c)) rd_mux = rd_val[c];
    end
    bus_rdata_d = rd_ok ? rd_mux : '0;
    bus_error_d = acc_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_rdata_q <= '0;
      bus_error_q <= 1'b0;
    end else begin
      bus_rdata_q <= bus_rdata_d;
      bus_error_q <= bus_error_d;
    end
  end

  assign bus_rdata = bus_rdata_q;
  assign bus_error = bus_error_q;

`ifdef REQ_FIFO_MC_IRQ_EN
  logic irq_d, irq_q;
  assign irq_d = |irq_src;
  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= irq_d;
  end
  assign irq = irq_q;
`else
  logic unused_irq;
  assign unused_irq = |irq_src;
`endif

endmodule

// File: tb/tb_req_fifo_mc.sv
// Bench for req_fifo_mc: directed plus random bus/push traffic against a queue-based model.
// Exercises the interrupt path too when built with REQ_FIFO_MC_IRQ_EN.
module tb_req_fifo_mc;
  localparam int DATA_W = 5;
  localparam int DEPTH  = 16;
  localparam int NCH    = 2;
  localparam int CH_W   = 1;
  localparam int AW     = CH_W + 3;
`ifdef REQ_FIFO_MC_IRQ_EN
  localparam int RSV_FROM = 5;
`else
  localparam int RSV_FROM = 4;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NCH-1:0]        push;
  logic [NCH*DATA_W-1:0] push_data;
  logic [NCH-1:0]        overflow;
  logic                  bus_ren, bus_wen;
  logic [AW-1:0]         bus_addr;
  logic [31:0]           bus_wdata, bus_rdata;
  logic                  bus_error;
`ifdef REQ_FIFO_MC_IRQ_EN
  logic                  irq;
`endif

  req_fifo_mc #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NCH(NCH)) dut (
    .clk(clk), .rst(rst), .push(push), .push_data(push_data), .overflow(overflow),
`ifdef REQ_FIFO_MC_IRQ_EN
    .irq(irq),
`endif
    .bus_ren(bus_ren), .bus_wen(bus_wen), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  // Reference model: one queue and flag set per channel.
  logic [DATA_W-1:0] mq [NCH][$];
  bit                m_ovf [NCH];
  bit                m_udr [NCH];
  logic [2:0]        m_mask [NCH];

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] ad(input int ch, input int rg);
    return {ch[CH_W-1:0], rg[2:0]};
  endfunction

  function automatic logic [NCH*DATA_W-1:0] pdat(input int c, input logic [DATA_W-1:0] v);
    logic [NCH*DATA_W-1:0] r;
    r = '0;
    r[c*DATA_W +: DATA_W] = v;
    return r;
  endfunction

  function automatic logic [31:0] model_ovf_vec();
    logic [31:0] r;
    r = '0;
    for (int c = 0; c < NCH; c++) r[c] = m_ovf[c];
    return r;
  endfunction

  task automatic clear_inputs();
    push = '0; push_data = '0; bus_ren = 1'b0; bus_wen = 1'b0; bus_addr = '0; bus_wdata = '0;
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
      m_ovf[c] = 0; m_udr[c] = 0; m_mask[c] = 3'b000;
    end
  endtask

  // One clock of traffic: drive, predict from the pre-edge model state, advance, check.
  task automatic step(input logic [NCH-1:0] p, input logic [NCH*DATA_W-1:0] pd,
                      input logic ren, input logic wen, input logic [AW-1:0] addr,
                      input logic [31:0] wd, input string tag);
    int ch, rg, sz[NCH];
    bit e, ei, popping;
    logic [31:0] rv;
    push = p; push_data = pd; bus_ren = ren; bus_wen = wen; bus_addr = addr; bus_wdata = wd;
    ch = int'(addr[AW-1:3]);
    rg = int'(addr[2:0]);
    e = (ren && wen) || ((ren || wen) &&
        (ch >= NCH || rg >= RSV_FROM || (wen && (rg == 0 || rg == 2 || rg == 3))));
    ei = 0;
    for (int c = 0; c < NCH; c++) begin
      sz[c] = mq[c].size();
      if ((m_mask[c][0] && sz[c] > 0) || (m_mask[c][1] && m_ovf[c]) || (m_mask[c][2] && m_udr[c]))
        ei = 1;
    end
    rv = 0;
    if (ren && !e) begin
      case (rg)
        0: rv = sz[ch];
        1: rv = {28'd0, sz[ch] == DEPTH, sz[ch] == 0, m_udr[ch], m_ovf[ch]};
        2, 3: rv = (sz[ch] > 0) ? 32'(mq[ch][0]) : 32'd0;
        4: rv = 32'(m_mask[ch]);
        default: rv = 0;
      endcase
    end
    if (wen && !e && rg == 1) begin
      if (wd[0]) m_ovf[ch] = 0;
      if (wd[1]) m_udr[ch] = 0;
    end
    if (wen && !e && rg == 4) m_mask[ch] = wd[2:0];
    popping = ren && !e && rg == 2;
    if (popping) begin
      if (sz[ch] > 0) void'(mq[ch].pop_front());
      else m_udr[ch] = 1;
    end
    for (int c = 0; c < NCH; c++) begin
      if (p[c]) begin
        if (sz[c] < DEPTH || (popping && ch == c)) mq[c].push_back(pd[c*DATA_W +: DATA_W]);
        else m_ovf[c] = 1;
      end
    end
    @(posedge clk); #1;
    clear_inputs();
    chk({tag, ".rdata"}, bus_rdata, rv);
    chk({tag, ".error"}, 32'(bus_error), 32'(e));
    chk({tag, ".overflow"}, 32'(overflow), model_ovf_vec());
`ifdef REQ_FIFO_MC_IRQ_EN
    chk({tag, ".irq"}, 32'(irq), 32'(ei));
`endif
    $display("step %-10s ren=%0b wen=%0b addr=%h wd=%h push=%b rdata=%h err=%0b ovf=%b",
             tag, ren, wen, addr, wd, p, bus_rdata, bus_error, overflow);
  endtask

  task automatic idle(input string tag);
    step('0, '0, 1'b0, 1'b0, '0, 32'd0, tag);
  endtask

  task automatic rd(input int ch, input int rg, input string tag);
    step('0, '0, 1'b1, 1'b0, ad(ch, rg), 32'd0, tag);
  endtask

  task automatic wr(input int ch, input int rg, input logic [31:0] d, input string tag);
    step('0, '0, 1'b0, 1'b1, ad(ch, rg), d, tag);
  endtask

  task automatic psh(input int c, input logic [DATA_W-1:0] v, input string tag);
    logic [NCH-1:0] pv;
    pv = '0; pv[c] = 1'b1;
    step(pv, pdat(c, v), 1'b0, 1'b0, '0, 32'd0, tag);
  endtask

  // Reset with traffic in flight: the cycle after must show nothing of it.
  task automatic do_reset(input string tag);
    rst = 1'b1; push = '1; push_data = '1; bus_ren = 1'b1; bus_addr = ad(0, 2);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_inputs();
    model_reset();
    chk({tag, ".rdata"}, bus_rdata, 32'd0);
    chk({tag, ".error"}, 32'(bus_error), 32'd0);
    chk({tag, ".overflow"}, 32'(overflow), 32'd0);
`ifdef REQ_FIFO_MC_IRQ_EN
    chk({tag, ".irq"}, 32'(irq), 32'd0);
`endif
    $display("reset %s rdata=%h err=%0b ovf=%b", tag, bus_rdata, bus_error, overflow);
  endtask

  initial begin
    logic [NCH-1:0] pv;
    logic [NCH*DATA_W-1:0] pd;
    int r;
    rst = 1'b1;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset("reset0");
    rd(0, 0, "cnt0_rst"); rd(1, 0, "cnt1_rst");

    psh(0, 5'h03, "t1_push"); psh(0, 5'h07, "t1_push"); psh(0, 5'h1F, "t1_push");
    rd(0, 0, "t1_count");
    chk("t1_count_is_3", bus_rdata, 32'd3);
    rd(0, 2, "t1_pop"); chk("t1_pop0", bus_rdata, 32'h03);
    rd(0, 2, "t1_pop"); chk("t1_pop1", bus_rdata, 32'h07);
    rd(0, 2, "t1_pop"); chk("t1_pop2", bus_rdata, 32'h1F);
    rd(0, 0, "t1_count0");

    for (int i = 0; i < DEPTH + 1; i++) psh(1, 5'(i + 1), "t2_fill");
    chk("t2_ovf1", 32'(overflow[1]), 32'd1);
    rd(1, 0, "t2_count"); chk("t2_count16", bus_rdata, 32'd16);
    rd(1, 1, "t2_status"); chk("t2_status9", bus_rdata, 32'h9);
    wr(1, 1, 32'h1, "t2_w1c");
    rd(1, 1, "t2_status"); chk("t2_status8", bus_rdata, 32'h8);

    rd(0, 2, "t3_udr_pop");
    rd(0, 1, "t3_status"); chk("t3_udr_set", bus_rdata, 32'h6);
    wr(0, 1, 32'h2, "t3_w1c");
    rd(0, 3, "t3_peek");
    rd(0, 1, "t3_status"); chk("t3_peek_no_udr", bus_rdata, 32'h4);
    step(2'b01, pdat(0, 5'h05), 1'b1, 1'b0, ad(0, 2), 32'd0, "t3_push_pop");
    rd(0, 0, "t3_count1");
    rd(0, 2, "t3_pop05");

    for (int i = 0; i < DEPTH; i++) psh(0, 5'($urandom_range(0, 31)), "t4_fill");
    step(2'b01, pdat(0, 5'h0A), 1'b1, 1'b0, ad(0, 2), 32'd0, "t4_full_pp");
    rd(0, 0, "t4_count16");
    for (int i = 0; i < 40; i++)
      step(2'b01, pdat(0, 5'($urandom_range(0, 31))), 1'b1, 1'b0, ad(0, 2), 32'd0, "t4_wrap");
    for (int i = 0; i < DEPTH; i++) rd(0, 2, "t4_drain");

    rd(0, 6, "t5_rsv6"); rd(1, 5, "t5_rsv5"); rd(0, 7, "t5_rsv7");
    wr(1, 2, 32'h1F, "t5_wr_pop"); wr(1, 0, 32'h0, "t5_wr_cnt"); wr(0, 3, 32'h3, "t5_wr_peek");
    step('0, '0, 1'b1, 1'b1, ad(1, 2), 32'd0, "t5_both");
`ifndef REQ_FIFO_MC_IRQ_EN
    rd(0, 4, "t5_rsv4");
`endif
    rd(1, 0, "t5_cnt_kept");

`ifdef REQ_FIFO_MC_IRQ_EN
    do_reset("t6_reset");
    wr(1, 4, 32'h1, "t6_mask");
    psh(1, 5'h11, "t6_push");
    idle("t6_irq_hi");
    chk("t6_irq_set", 32'(irq), 32'd1);
    rd(1, 2, "t6_pop");
    idle("t6_irq_lo");
    chk("t6_irq_clr", 32'(irq), 32'd0);
    wr(0, 4, 32'h7, "t6_mask0");
    psh(0, 5'h02, "t6_push0");
    rd(0, 4, "t6_mask_rd");
`endif

    for (int i = 0; i < 300; i++) begin
      pv = 2'($urandom_range(0, 3));
      pd = NCH*DATA_W'($urandom);
      r = $urandom_range(0, 9);
      if (r <= 5)      step(pv, pd, 1'b1, 1'b0, ad($urandom_range(0, 1), $urandom_range(0, 7)), 32'd0, "rnd_rd");
      else if (r <= 7) step(pv, pd, 1'b0, 1'b1, ad($urandom_range(0, 1), 1), $urandom, "rnd_w1c");
      else if (r == 8) step(pv, pd, 1'b0, 1'b1, ad($urandom_range(0, 1), $urandom_range(0, 7)), $urandom, "rnd_wr");
      else             step(pv, pd, 1'b1, 1'b1, ad($urandom_range(0, 1), $urandom_range(0, 7)), 32'd0, "rnd_both");
    end

    psh(0, 5'h0C, "t7_push"); psh(1, 5'h0D, "t7_push");
    do_reset("t7_midrst");
    rd(0, 0, "t7_cnt0"); rd(1, 0, "t7_cnt1");
    rd(0, 2, "t7_pop_empty");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
